// File: rtl/osd_spi_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : osd_spi_ctrl                                              |
// | Core-side SPI master for the OSD overlay: show/hide and line write |
// | Option : OSD_CMD_FILL_EN - req_cmd 3 writes a line of req_fill     |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module osd_spi_ctrl #(
   parameter int CLK_DIV    = 4,
   parameter int LINE_BYTES = 256,
   parameter int GAP_CYCLES = 8
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_cmd,
   input  logic [2:0] req_line,
   input  logic [7:0] req_fill,
   input  logic       data_valid,
   output logic       data_ready,
   input  logic [7:0] data_byte,
   output logic       busy,
   output logic       done,
   output logic       SPI_SCK,
   output logic       SPI_SS3,
   output logic       SPI_DI
);

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_LOAD   = 3'd1;
   localparam logic [2:0] c_ST_BIT_LO = 3'd2;
   localparam logic [2:0] c_ST_BIT_HI = 3'd3;
   localparam logic [2:0] c_ST_FETCH  = 3'd4;
   localparam logic [2:0] c_ST_GAP    = 3'd5;

   localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] c_GAP_LAST = 8'(GAP_CYCLES - 1);
   localparam logic [8:0] c_LINE_LEN = 9'(LINE_BYTES);

   logic [2:0] r_state;
   logic       r_req_ready;
   logic       r_busy;
   logic       r_done;
   logic       r_data_ready;
   logic       r_sck;
   logic       r_ss3;
   logic       r_di;
   logic [1:0] r_cmd;
   logic [2:0] r_line;
   logic [7:0] r_fill;
   logic [7:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic [8:0] r_byte_cnt;
   logic [7:0] r_div_cnt;

   logic [7:0] w_cmd_byte;
   logic [7:0] w_fetch_byte;
   logic       w_is_write;
   logic       w_is_fill;
   logic       w_is_noop;
   logic       w_fetch_take;

`ifdef OSD_CMD_FILL_EN
   assign w_is_fill  = (r_cmd == 2'd3);
   assign w_is_noop  = 1'b0;
`else
   assign w_is_fill  = 1'b0;
   assign w_is_noop  = (r_cmd == 2'd3);
`endif
   assign w_is_write = (r_cmd == 2'd2) || w_is_fill;

   always_comb begin
      w_cmd_byte = {5'b00100, r_line};
      case (r_cmd)
         2'd0:    w_cmd_byte = 8'h40;
         2'd1:    w_cmd_byte = 8'h41;
         default: w_cmd_byte = {5'b00100, r_line};
      endcase
   end

   // Fill lines load in one cycle; streamed lines wait for the byte handshake.
   assign w_fetch_byte = w_is_fill ? r_fill : data_byte;
   assign w_fetch_take = w_is_fill || (data_valid && r_data_ready);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= c_ST_IDLE;
         r_req_ready  <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_data_ready <= 1'b0;
         r_sck        <= 1'b0;
         r_ss3        <= 1'b1;
         r_di         <= 1'b0;
         r_cmd        <= 2'd0;
         r_line       <= 3'd0;
         r_fill       <= 8'h00;
         r_shift      <= 8'h00;
         r_bit_cnt    <= 3'd0;
         r_byte_cnt   <= 9'd0;
         r_div_cnt    <= 8'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               r_req_ready <= 1'b1;
               if (req_valid && r_req_ready) begin
                  r_cmd       <= req_cmd;
                  r_line      <= req_line;
                  r_fill      <= req_fill;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= c_ST_LOAD;
               end
            end
            c_ST_LOAD: begin
               if (w_is_noop) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= c_ST_IDLE;
               end else begin
                  r_shift    <= w_cmd_byte;
                  r_di       <= w_cmd_byte[7];
                  r_ss3      <= 1'b0;
                  r_byte_cnt <= 9'd0;
                  r_bit_cnt  <= 3'd0;
                  r_div_cnt  <= 8'd0;
                  r_state    <= c_ST_BIT_LO;
               end
            end
            c_ST_BIT_LO: begin
               if (r_div_cnt == c_DIV_LAST) begin
                  r_div_cnt <= 8'd0;
                  r_sck     <= 1'b1;
                  r_state   <= c_ST_BIT_HI;
               end else begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end
            end
            c_ST_BIT_HI: begin
               if (r_div_cnt == c_DIV_LAST) begin
                  r_div_cnt <= 8'd0;
                  r_sck     <= 1'b0;
                  r_shift   <= {r_shift[6:0], 1'b0};
                  r_di      <= r_shift[6];
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     if (w_is_write && (r_byte_cnt < c_LINE_LEN)) begin
                        r_data_ready <= ~w_is_fill;
                        r_state      <= c_ST_FETCH;
                     end else begin
                        r_ss3   <= 1'b1;
                        r_di    <= 1'b0;
                        r_state <= c_ST_GAP;
                     end
                  end else begin
                     r_state <= c_ST_BIT_LO;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end
            end
            c_ST_FETCH: begin
               if (w_fetch_take) begin
                  r_shift      <= w_fetch_byte;
                  r_di         <= w_fetch_byte[7];
                  r_byte_cnt   <= r_byte_cnt + 9'd1;
                  r_data_ready <= 1'b0;
                  r_div_cnt    <= 8'd0;
                  r_state      <= c_ST_BIT_LO;
               end
            end
            c_ST_GAP: begin
               if (r_div_cnt == c_GAP_LAST) begin
                  r_div_cnt <= 8'd0;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= c_ST_IDLE;
               end else begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign busy       = r_busy;
   assign done       = r_done;
   assign data_ready = r_data_ready;
   assign SPI_SCK    = r_sck;
   assign SPI_SS3    = r_ss3;
   assign SPI_DI     = r_di;

endmodule
`default_nettype wire

// File: tb/tb_osd_spi_ctrl.sv
`default_nettype none
// Bench for osd_spi_ctrl: overlay model decodes the SPI frames, vectors hold hand-computed results.
module tb_osd_spi_ctrl;

   localparam int CLK_DIV    = 2;
   localparam int LINE_BYTES = 256;
   localparam int GAP_CYCLES = 8;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_cmd = 2'd0;
   logic [2:0] req_line = 3'd0;
   logic [7:0] req_fill = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_ready;
   logic [7:0] data_byte = 8'h00;
   logic       busy;
   logic       done;
   logic       SPI_SCK;
   logic       SPI_SS3;
   logic       SPI_DI;

   always #5 clk_sys = ~clk_sys;

   osd_spi_ctrl #(
      .CLK_DIV    (CLK_DIV),
      .LINE_BYTES (LINE_BYTES),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_cmd    (req_cmd),
      .req_line   (req_line),
      .req_fill   (req_fill),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .data_byte  (data_byte),
      .busy       (busy),
      .done       (done),
      .SPI_SCK    (SPI_SCK),
      .SPI_SS3    (SPI_SS3),
      .SPI_DI     (SPI_DI)
   );

   int cyc = 0;
   int hs_cnt = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;
   always @(posedge clk_sys) if (data_valid && data_ready) hs_cnt <= hs_cnt + 1;

   int n_cmp = 0;
   int n_err = 0;

   // stimulus controls written by the main sequence
   bit pay_en = 1'b0;
   bit stall_en = 1'b0;
   int hs_base = 0;

   // overlay model and monitors
   logic [7:0]  m_sr = 8'h00;
   logic [7:0]  last_cmd = 8'h00;
   logic        m_wr = 1'b0;
   logic        osd_en = 1'b0;
   logic [10:0] m_addr = 11'd0;
   logic [7:0]  ovl_buf [2048];
   int          ovl_tag [2048];
   int m_bits = 0, m_nbytes = 0, m_frames = 0, m_rises = 0, m_ss_low = 0;
   int m_dr = 0, m_dr_bad = 0, m_done = 0, hi_run = 0, last_gap = 0;
   int stall_ctr = 0, stall_bad = 0, rise_cyc = 0, next_rise_cyc = 0;
   bit rise_seen = 1'b0, next_seen = 1'b0;
   logic prev_sck = 1'b0, prev_ss = 1'b1;

   initial begin
      int idx;
      forever begin
         @(negedge clk_sys);
         idx = hs_cnt - hs_base;
         data_byte = idx[7:0];
         if (!stall_en) begin
            stall_ctr = 0; stall_bad = 0; rise_seen = 1'b0; next_seen = 1'b0;
         end
         // after payload byte 100 is taken, hold the source off for 20 FETCH cycles
         if (stall_en && idx == 101 && data_ready && stall_ctr < 20) begin
            data_valid = 1'b0;
            stall_ctr++;
            if (SPI_SCK || SPI_SS3) stall_bad++;
         end else begin
            data_valid = pay_en;
            if (stall_en && stall_ctr == 20 && !rise_seen && pay_en) begin
               rise_seen = 1'b1;
               rise_cyc  = cyc;
            end
         end

         if (!SPI_SS3) m_ss_low++;
         if (data_ready) m_dr++;
         if (data_ready && (SPI_SCK || SPI_SS3)) m_dr_bad++;
         if (done) m_done++;
         if (SPI_SS3) hi_run++;
         else begin
            if (prev_ss) last_gap = hi_run;
            hi_run = 0;
         end
         if (!SPI_SS3 && prev_ss) begin
            m_bits = 0; m_nbytes = 0;
         end
         if (!SPI_SS3 && SPI_SCK && !prev_sck) begin
            m_rises++;
            if (rise_seen && !next_seen) begin
               next_seen = 1'b1;
               next_rise_cyc = cyc;
            end
            m_sr = {m_sr[6:0], SPI_DI};
            m_bits++;
            if (m_bits == 8) begin
               m_bits = 0;
               if (m_nbytes == 0) begin
                  last_cmd = m_sr;
                  m_frames++;
                  if (m_sr == 8'h40) osd_en = 1'b0;
                  if (m_sr == 8'h41) osd_en = 1'b1;
                  m_wr   = (m_sr[7:3] == 5'b00100);
                  m_addr = {m_sr[2:0], 8'h00};
               end else if (m_wr) begin
                  ovl_buf[m_addr] = m_sr;
                  ovl_tag[m_addr] = m_frames;
                  m_addr = m_addr + 11'd1;
               end
               m_nbytes++;
            end
         end
         prev_sck = SPI_SCK;
         prev_ss  = SPI_SS3;
      end
   end

   typedef struct {
      logic [1:0] cmd;
      logic [2:0] line;
      logic [7:0] fill;
      bit         stall;
      int         exp_frames;
      logic [7:0] exp_cmd;
      bit         exp_en;
      int         exp_ss_low;
      int         exp_rises;
      int         exp_dr;
      int         exp_lat;
      int         buf_kind;   // 0 none, 1 ramp 0..255, 2 fill byte
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      if (!req_ready) begin
         n_cmp++; n_err++;
         $display("FAIL req_ready_timeout: req_ready=0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic send_req(input logic [1:0] cmd, input logic [2:0] line,
                           input logic [7:0] fill, output int acc_cyc);
      @(negedge clk_sys);
      req_cmd = cmd; req_line = line; req_fill = fill; req_valid = 1'b1;
      wait_ready();
      acc_cyc = cyc;
      @(negedge clk_sys);
      req_valid = 1'b0;
   endtask

   task automatic wait_done(output int done_cyc);
      int n = 0;
      do begin
         @(negedge clk_sys);
         n++;
      end while (!done && n < 20000);
      done_cyc = cyc;
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout: done=0 after %0d cycles, expected a pulse", n);
      end
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic run_vec(input vec_t v, input int k);
      int f0, r0, s0, d0, dn0, h0, acc, dc, bad_buf, bad_tag;
      logic [7:0]  b;
      logic [7:0]  eb;
      logic [10:0] a;
      pay_en = (v.cmd == 2'd2);
      stall_en = v.stall;
      hs_base = hs_cnt;
      f0 = m_frames; r0 = m_rises; s0 = m_ss_low; d0 = m_dr; dn0 = m_done; h0 = hs_cnt;
      send_req(v.cmd, v.line, v.fill, acc);
      wait_done(dc);
      check($sformatf("v%0d_frames", k), m_frames - f0, v.exp_frames);
      if (v.exp_frames > 0) check($sformatf("v%0d_cmd_byte", k), int'(last_cmd), int'(v.exp_cmd));
      check($sformatf("v%0d_osd_enable", k), int'(osd_en), int'(v.exp_en));
      check($sformatf("v%0d_ss3_low_cycles", k), m_ss_low - s0, v.exp_ss_low);
      check($sformatf("v%0d_sck_rises", k), m_rises - r0, v.exp_rises);
      check($sformatf("v%0d_data_ready_cycles", k), m_dr - d0, v.exp_dr);
      check($sformatf("v%0d_done_latency", k), dc - acc, v.exp_lat);
      check($sformatf("v%0d_done_pulses", k), m_done - dn0, 1);
      check($sformatf("v%0d_payload_taken", k), hs_cnt - h0, (v.cmd == 2'd2) ? 256 : 0);
      if (v.buf_kind != 0) begin
         bad_buf = 0; bad_tag = 0;
         for (int i = 0; i < 256; i++) begin
            b  = 8'(i);
            a  = {v.line, b};
            eb = (v.buf_kind == 1) ? b : v.fill;
            if (ovl_buf[a] != eb) bad_buf++;
            if (ovl_tag[a] != f0 + 1) bad_tag++;
         end
         check($sformatf("v%0d_buffer_bad_bytes", k), bad_buf, 0);
         check($sformatf("v%0d_buffer_stale_bytes", k), bad_tag, 0);
      end
      if (v.stall) begin
         check($sformatf("v%0d_stall_cycles", k), stall_ctr, 20);
         check($sformatf("v%0d_stall_sck_ss3_active", k), stall_bad, 0);
         check($sformatf("v%0d_resume_seen", k), int'(next_seen), 1);
         check($sformatf("v%0d_resume_delay", k), next_rise_cyc - rise_cyc, 1 + CLK_DIV);
      end
      pay_en = 1'b0;
      stall_en = 1'b0;
   endtask

   initial begin
      int acc, dc, f0, d0, n;
      // cmd, line, fill, stall, frames, cmd byte, osd_en, SS3 low, SCK rises, data_ready cycles, latency, buf
      vecs[0] = '{2'd0, 3'd0, 8'h00, 1'b0, 1, 8'h40, 1'b0,   32,    8,   0,   42, 0};
      vecs[1] = '{2'd1, 3'd0, 8'h00, 1'b0, 1, 8'h41, 1'b1,   32,    8,   0,   42, 0};
      vecs[2] = '{2'd2, 3'd5, 8'h00, 1'b0, 1, 8'h25, 1'b1, 8480, 2056, 256, 8490, 1};
      vecs[3] = '{2'd2, 3'd5, 8'h00, 1'b1, 1, 8'h25, 1'b1, 8500, 2056, 276, 8510, 1};
`ifdef OSD_CMD_FILL_EN
      vecs[4] = '{2'd3, 3'd2, 8'hA5, 1'b0, 1, 8'h22, 1'b1, 8480, 2056,   0, 8490, 2};
`else
      vecs[4] = '{2'd3, 3'd2, 8'hA5, 1'b0, 0, 8'h00, 1'b1,    0,    0,   0,    2, 0};
`endif
      vecs[5] = '{2'd0, 3'd0, 8'h00, 1'b0, 1, 8'h40, 1'b0,   32,    8,   0,   42, 0};

      repeat (3) @(negedge clk_sys);
      check("rst_req_ready", int'(req_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_data_ready", int'(data_ready), 0);
      check("rst_sck", int'(SPI_SCK), 0);
      check("rst_ss3", int'(SPI_SS3), 1);
      check("rst_di", int'(SPI_DI), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // reset asserted in the middle of payload byte 40
      pay_en = 1'b1;
      hs_base = hs_cnt;
      send_req(2'd2, 3'd5, 8'h00, acc);
      n = 0;
      while (!(m_nbytes == 41 && m_bits == 4) && n < 20000) begin
         @(negedge clk_sys);
         n++;
      end
      if (n >= 20000) begin
         n_cmp++; n_err++;
         $display("FAIL midframe_wait_timeout: byte %0d bit %0d, expected byte 41 bit 4", m_nbytes, m_bits);
      end
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_ss3", int'(SPI_SS3), 1);
      check("arst_sck", int'(SPI_SCK), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_req_ready", int'(req_ready), 1);
      check("arst_data_ready", int'(data_ready), 0);
      @(negedge clk_sys);
      pay_en = 1'b0;
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      f0 = m_frames;
      send_req(2'd1, 3'd0, 8'h00, acc);
      wait_done(dc);
      check("post_rst_frames", m_frames - f0, 1);
      check("post_rst_cmd_byte", int'(last_cmd), 8'h41);
      check("post_rst_osd_enable", int'(osd_en), 1);
      check("post_rst_latency", dc - acc, 42);

      // disable then enable with req_valid held across both acceptances
      f0 = m_frames; d0 = m_done;
      @(negedge clk_sys);
      req_cmd = 2'd0; req_line = 3'd0; req_valid = 1'b1;
      wait_ready();
      @(negedge clk_sys);
      req_cmd = 2'd1;
      wait_ready();
      @(negedge clk_sys);
      req_valid = 1'b0;
      wait_done(dc);
      check("b2b_frames", m_frames - f0, 2);
      check("b2b_done_pulses", m_done - d0, 2);
      check("b2b_cmd_byte", int'(last_cmd), 8'h41);
      check("b2b_osd_enable", int'(osd_en), 1);
      n_cmp++;
      if (last_gap < GAP_CYCLES + 2) begin
         n_err++;
         $display("FAIL b2b_ss3_gap: got %0d cycles, expected at least %0d", last_gap, GAP_CYCLES + 2);
      end

      check("data_ready_outside_fetch", m_dr_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
